branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Parametrised dynamic branch predictor with a branch target buffer (BTB) for the 16-bit pipelined processor.
- Replaces static predict-not-taken handling of BEQ/BNE:
  - IF stage looks up IF_PC and receives a predicted next PC in the same cycle.
  - EX stage returns the resolved outcome, which trains the table and raises a mispredict/redirect.
- Exposes a debug read port in the style of inr/out_value, plus saturating statistics counters.

Parameters:
- DataWidth, 16, PC/target width.
- IndexBits, 3, log2 of table entries (8 entries); table index is PC[IndexBits-1:0].
- TagBits, DataWidth-IndexBits, stored tag width (PC upper bits).
- CounterInit, 2'b01, 2-bit counter value after reset (weakly not-taken).
- AllocInit, 2'b10, counter value written on allocation (weakly taken).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous reset, active-low.
- IF_PC  in  DataWidth  fetch PC.
- Pred_Taken  out  1  predicted taken for IF_PC (combinational).
- Pred_Target  out  DataWidth  predicted next PC (combinational).
- EX_Valid  in  1  branch resolved this cycle.
- EX_PC  in  DataWidth  PC of the resolved branch.
- EX_Taken  in  1  actual outcome.
- EX_Target  in  DataWidth  actual taken target.
- EX_PredTaken  in  1  prediction carried down the pipe with this branch.
- EX_PredTarget  in  DataWidth  predicted next PC carried down the pipe.
- Flush_All  in  1  synchronous invalidate of the whole table.
- Mispredict  out  1  combinational; resolved branch was mispredicted.
- Redirect_PC  out  DataWidth  correct next PC when Mispredict is high.
- Dbg_Idx  in  IndexBits  debug entry select.
- Dbg_Value  out  DataWidth  {valid, counter[1:0], target[DataWidth-4:0]} of the selected entry.
- Branch_Count  out  DataWidth  resolved branches, saturating.
- Mispredict_Count  out  DataWidth  mispredictions, saturating.

Behaviour:
- Entry state: valid, tag[TagBits], counter[2], target[DataWidth].
- Reset (RST=0, asynchronous, any time including mid-update):
  - all valid bits = 0, counters = CounterInit, targets = 0, both statistics counts = 0.
  - Outputs settle to their lookup/compare values; there are no registered outputs other than the statistics counts.
- Lookup (zero latency):
  - hit = valid && tag == IF_PC[DataWidth-1:IndexBits].
  - Pred_Taken = hit && counter[1].
  - Pred_Target = Pred_Taken ? target : IF_PC+1 (modulo 2^DataWidth; 16'hFFFF+1 = 0).
- Mispredict = EX_Valid && ((EX_Taken != EX_PredTaken) || (EX_Taken && EX_Target != EX_PredTarget)).
- Redirect_PC = EX_Taken ? EX_Target : EX_PC+1. Its value is don't-care when Mispredict = 0, but it is computed as stated.
- Update, at the rising edge when EX_Valid=1 and Flush_All=0:
  - Hit, taken: counter increments, saturating at 2'b11; target <= EX_Target.
  - Hit, not-taken: counter decrements, saturating at 2'b00; target unchanged.
  - Miss, taken: allocate, overwriting any valid entry with a different tag. valid <= 1, tag <= EX_PC upper bits, counter <= AllocInit, target <= EX_Target.
  - Miss, not-taken: no change.
- Lookup and update to the same index in the same cycle: the lookup returns the pre-update value; there is no bypass.
- Flush_All=1: at the edge, all valid bits are cleared. Flush wins over a simultaneous update. Counters and targets keep their values; the statistics counts are unaffected.
- Statistics, at each edge with EX_Valid=1 (independent of Flush_All):
  - Branch_Count += 1.
  - Mispredict_Count += Mispredict.
  - Both saturate at all-ones.
- Dbg_Value: combinational read of entry Dbg_Idx.

Decomposition:
- Shared package holds:
  - counter constants: STRONG_NT=2'b00, WEAK_NT=2'b01, WEAK_T=2'b10, STRONG_T=2'b11;
  - a 2-bit saturating-update function.
- One sub-module, bp_entry_table: storage with an asynchronous read port (lookup), a second asynchronous read port (debug), one synchronous write port, and a flush input.
- Top level holds the compare logic, redirect logic and statistics counters.

Test Plan:
- Reset then lookup: RST low 10 ns, IF_PC=16'h0002 -> Pred_Taken=0, Pred_Target=16'h0003; all debug entries read valid=0, counter=01; both counts 0.
- Allocate on taken BEQ: EX_Valid, EX_PC=2, EX_Taken=1, EX_Target=4, EX_PredTaken=0, EX_PredTarget=3 -> Mispredict=1, Redirect_PC=4, then Mispredict_Count=1. Next cycle IF_PC=2 -> Pred_Taken=1, Pred_Target=4.
- Saturation:
  - train entry 2 taken 3 more times -> counter=11;
  - one not-taken -> counter=10 and still predicts taken;
  - second not-taken -> counter=01, predicts not-taken, Pred_Target=3.
- Alias/tag miss: entry allocated for PC=16'h0002, lookup IF_PC=16'h000A (same index) -> Pred_Taken=0, Pred_Target=16'h000B. A taken branch at 16'h000A overwrites the tag.
- Correct prediction and not-taken redirect:
  - EX_Taken=1, EX_PredTaken=1, equal targets -> Mispredict=0, Branch_Count increments only.
  - EX_Taken=0 with EX_PredTaken=1, EX_PC=16'hFFFF -> Mispredict=1, Redirect_PC=16'h0000.
- Flush and async reset: Flush_All coincident with a taken update -> all entries invalid and the update is dropped. RST asserted mid-cycle -> counts and valid bits clear immediately, without waiting for CLK.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared 2-bit counter encodings and the saturating counter update used by the
// branch predictor table.
package branch_predictor_pkg;

  localparam logic [1:0] STRONG_NT = 2'b00;
  localparam logic [1:0] WEAK_NT   = 2'b01;
  localparam logic [1:0] WEAK_T    = 2'b10;
  localparam logic [1:0] STRONG_T  = 2'b11;

  function automatic logic [1:0] satUpdate(input logic [1:0] ctr, input logic taken);
    logic [1:0] next;
    next = ctr;
    if (taken) begin
      if (ctr != STRONG_T) next = ctr + 2'd1;
    end else begin
      if (ctr != STRONG_NT) next = ctr - 2'd1;
    end
    return next;
  endfunction

endpackage

// File: rtl/bp_entry_table.sv
// Predictor storage: valid/tag/counter/target per entry, two asynchronous read
// ports (fetch lookup, debug) and one read-modify-write update port.
module bp_entry_table import branch_predictor_pkg::*; #(
  parameter int         DataWidth   = 16,
  parameter int         IndexBits   = 3,
  parameter int         TagBits     = DataWidth - IndexBits,
  parameter logic [1:0] CounterInit = WEAK_NT,
  parameter logic [1:0] AllocInit   = WEAK_T
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [IndexBits-1:0] lookupIdx,
  output logic                 lookupValid,
  output logic [TagBits-1:0]   lookupTag,
  output logic [1:0]           lookupCtr,
  output logic [DataWidth-1:0] lookupTarget,
  input  logic [IndexBits-1:0] dbgIdx,
  output logic [DataWidth-1:0] dbgValue,
  input  logic                 wrEn,
  input  logic [IndexBits-1:0] wrIdx,
  input  logic [TagBits-1:0]   wrTag,
  input  logic                 wrTaken,
  input  logic [DataWidth-1:0] wrTarget,
  input  logic                 flush
);

  localparam int Entries = 1 << IndexBits;

  logic [Entries-1:0]   valid;
  logic [TagBits-1:0]   tags    [Entries];
  logic [1:0]           ctrs    [Entries];
  logic [DataWidth-1:0] targets [Entries];
  logic                 wrHit;

  assign lookupValid  = valid[lookupIdx];
  assign lookupTag    = tags[lookupIdx];
  assign lookupCtr    = ctrs[lookupIdx];
  assign lookupTarget = targets[lookupIdx];

  assign dbgValue = {valid[dbgIdx], ctrs[dbgIdx], targets[dbgIdx][DataWidth-4:0]};

  assign wrHit = valid[wrIdx] && (tags[wrIdx] == wrTag);

  // Flush only drops valid bits; counters and targets survive for re-allocation.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < Entries; i++) begin
        valid[i]   <= 1'b0;
        tags[i]    <= '0;
        ctrs[i]    <= CounterInit;
        targets[i] <= '0;
      end
    end else if (flush) begin
      valid <= '0;
    end else if (wrEn) begin
      if (wrHit) begin
        ctrs[wrIdx] <= satUpdate(ctrs[wrIdx], wrTaken);
        if (wrTaken) targets[wrIdx] <= wrTarget;
      end else if (wrTaken) begin
        valid[wrIdx]   <= 1'b1;
        tags[wrIdx]    <= wrTag;
        ctrs[wrIdx]    <= AllocInit;
        targets[wrIdx] <= wrTarget;
      end
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor with BTB: zero-latency fetch prediction, EX-stage
// training with mispredict/redirect, debug read port and saturating statistics.
module branch_predictor import branch_predictor_pkg::*; #(
  parameter int         DataWidth   = 16,
  parameter int         IndexBits   = 3,
  parameter int         TagBits     = DataWidth - IndexBits,
  parameter logic [1:0] CounterInit = WEAK_NT,
  parameter logic [1:0] AllocInit   = WEAK_T
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [DataWidth-1:0] IF_PC,
  output logic                 Pred_Taken,
  output logic [DataWidth-1:0] Pred_Target,
  input  logic                 EX_Valid,
  input  logic [DataWidth-1:0] EX_PC,
  input  logic                 EX_Taken,
  input  logic [DataWidth-1:0] EX_Target,
  input  logic                 EX_PredTaken,
  input  logic [DataWidth-1:0] EX_PredTarget,
  input  logic                 Flush_All,
  output logic                 Mispredict,
  output logic [DataWidth-1:0] Redirect_PC,
  input  logic [IndexBits-1:0] Dbg_Idx,
  output logic [DataWidth-1:0] Dbg_Value,
  output logic [DataWidth-1:0] Branch_Count,
  output logic [DataWidth-1:0] Mispredict_Count
);

  localparam logic [DataWidth-1:0] One = DataWidth'(1);

  logic                 lookupValid;
  logic [TagBits-1:0]   lookupTag;
  logic [1:0]           lookupCtr;
  logic [DataWidth-1:0] lookupTarget;
  logic                 ifHit;

  bp_entry_table #(
    .DataWidth  (DataWidth),
    .IndexBits  (IndexBits),
    .TagBits    (TagBits),
    .CounterInit(CounterInit),
    .AllocInit  (AllocInit)
  ) u_table (
    .CLK         (CLK),
    .RST         (RST),
    .lookupIdx   (IF_PC[IndexBits-1:0]),
    .lookupValid (lookupValid),
    .lookupTag   (lookupTag),
    .lookupCtr   (lookupCtr),
    .lookupTarget(lookupTarget),
    .dbgIdx      (Dbg_Idx),
    .dbgValue    (Dbg_Value),
    .wrEn        (EX_Valid),
    .wrIdx       (EX_PC[IndexBits-1:0]),
    .wrTag       (EX_PC[DataWidth-1:IndexBits]),
    .wrTaken     (EX_Taken),
    .wrTarget    (EX_Target),
    .flush       (Flush_All)
  );

  // EX_Valid is a one-cycle strobe with no back-pressure: the branch is
  // consumed (trained and counted) on the edge where it is high.
  assign ifHit       = lookupValid && (lookupTag == IF_PC[DataWidth-1:IndexBits]);
  assign Pred_Taken  = ifHit && lookupCtr[1];
  assign Pred_Target = Pred_Taken ? lookupTarget : IF_PC + One;

  assign Mispredict  = EX_Valid && ((EX_Taken != EX_PredTaken) ||
                                    (EX_Taken && (EX_Target != EX_PredTarget)));
  assign Redirect_PC = EX_Taken ? EX_Target : EX_PC + One;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      Branch_Count     <= '0;
      Mispredict_Count <= '0;
    end else if (EX_Valid) begin
      if (Branch_Count != '1) Branch_Count <= Branch_Count + One;
      if (Mispredict && (Mispredict_Count != '1)) Mispredict_Count <= Mispredict_Count + One;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus randomized
// traffic compared against an array-based behavioural model.
module tb_branch_predictor;

  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] IF_PC;
  logic        Pred_Taken;
  logic [15:0] Pred_Target;
  logic        EX_Valid;
  logic [15:0] EX_PC;
  logic        EX_Taken;
  logic [15:0] EX_Target;
  logic        EX_PredTaken;
  logic [15:0] EX_PredTarget;
  logic        Flush_All;
  logic        Mispredict;
  logic [15:0] Redirect_PC;
  logic [2:0]  Dbg_Idx;
  logic [15:0] Dbg_Value;
  logic [15:0] Branch_Count;
  logic [15:0] Mispredict_Count;

  int checks = 0;
  int errors = 0;
  logic [15:0] expQ[$];

  // Behavioural model: one record per table slot plus the two statistics.
  bit mValid[8];
  int mTag[8];
  int mCtr[8];
  int mTarget[8];
  int mBranch;
  int mMis;

  branch_predictor #(.DataWidth(16), .IndexBits(3)) dut (
    .CLK(CLK), .RST(RST), .IF_PC(IF_PC), .Pred_Taken(Pred_Taken), .Pred_Target(Pred_Target),
    .EX_Valid(EX_Valid), .EX_PC(EX_PC), .EX_Taken(EX_Taken), .EX_Target(EX_Target),
    .EX_PredTaken(EX_PredTaken), .EX_PredTarget(EX_PredTarget), .Flush_All(Flush_All),
    .Mispredict(Mispredict), .Redirect_PC(Redirect_PC), .Dbg_Idx(Dbg_Idx), .Dbg_Value(Dbg_Value),
    .Branch_Count(Branch_Count), .Mispredict_Count(Mispredict_Count)
  );

  // Clock
  always #5 CLK = ~CLK;

  task automatic checkVal(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Model
  task automatic modelReset();
    for (int i = 0; i < 8; i++) begin
      mValid[i] = 1'b0; mTag[i] = 0; mCtr[i] = 1; mTarget[i] = 0;
    end
    mBranch = 0;
    mMis = 0;
  endtask

  function automatic bit modelHit(input logic [15:0] pc);
    return mValid[pc % 8] && (mTag[pc % 8] == int'(pc) / 8);
  endfunction

  function automatic bit expPredTaken(input logic [15:0] pc);
    return modelHit(pc) && (mCtr[pc % 8] >= 2);
  endfunction

  function automatic logic [15:0] expPredTarget(input logic [15:0] pc);
    if (expPredTaken(pc)) return 16'(mTarget[pc % 8]);
    return 16'((int'(pc) + 1) % 65536);
  endfunction

  function automatic bit expMis();
    return EX_Valid && ((EX_Taken != EX_PredTaken) || (EX_Taken && (EX_Target != EX_PredTarget)));
  endfunction

  function automatic logic [15:0] expRedirect();
    if (EX_Taken) return EX_Target;
    return 16'((int'(EX_PC) + 1) % 65536);
  endfunction

  function automatic logic [15:0] expDbg(input int i);
    return 16'((int'(mValid[i]) * 32768) + (mCtr[i] * 8192) + (mTarget[i] % 8192));
  endfunction

  task automatic modelEdge();
    int idx;
    if (EX_Valid) begin
      if (mBranch < 65535) mBranch++;
      if (expMis() && mMis < 65535) mMis++;
    end
    if (Flush_All) begin
      for (int i = 0; i < 8; i++) mValid[i] = 1'b0;
    end else if (EX_Valid) begin
      idx = EX_PC % 8;
      if (modelHit(EX_PC)) begin
        if (EX_Taken) begin
          if (mCtr[idx] < 3) mCtr[idx]++;
          mTarget[idx] = EX_Target;
        end else if (mCtr[idx] > 0) begin
          mCtr[idx]--;
        end
      end else if (EX_Taken) begin
        mValid[idx] = 1'b1;
        mTag[idx] = int'(EX_PC) / 8;
        mCtr[idx] = 2;
        mTarget[idx] = EX_Target;
      end
    end
  endtask

  // Scoreboard: queue the model's view, then pop against the DUT outputs.
  task automatic scoreboard();
    string names[7] = '{"pred_taken", "pred_target", "mispredict", "redirect_pc",
                        "dbg_value", "branch_count", "mispredict_count"};
    logic [15:0] obs[7];
    expQ.push_back(16'(expPredTaken(IF_PC)));
    expQ.push_back(expPredTarget(IF_PC));
    expQ.push_back(16'(expMis()));
    expQ.push_back(expRedirect());
    expQ.push_back(expDbg(Dbg_Idx));
    expQ.push_back(16'(mBranch));
    expQ.push_back(16'(mMis));
    obs = '{16'(Pred_Taken), Pred_Target, 16'(Mispredict), Redirect_PC,
            Dbg_Value, Branch_Count, Mispredict_Count};
    for (int i = 0; i < 7; i++) checkVal(names[i], obs[i], expQ.pop_front());
  endtask

  // Drivers
  task automatic driveEx(input bit v, input logic [15:0] pc, input bit tk, input logic [15:0] tgt,
                         input bit pt, input logic [15:0] ptgt);
    EX_Valid = v; EX_PC = pc; EX_Taken = tk; EX_Target = tgt;
    EX_PredTaken = pt; EX_PredTarget = ptgt;
  endtask

  task automatic idleEx();
    driveEx(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
  endtask

  task automatic runCycle();
    @(negedge CLK);
    scoreboard();
    @(posedge CLK);
    modelEdge();
    #1;
  endtask

  task automatic checkDbgAll(input string tag);
    for (int i = 0; i < 8; i++) begin
      Dbg_Idx = 3'(i);
      #1;
      checkVal($sformatf("%s_dbg%0d", tag, i), Dbg_Value, expDbg(i));
    end
  endtask

  task automatic randomCycle();
    logic [15:0] pc;
    pc = ($urandom_range(0, 19) == 0) ? 16'hFFFF : 16'($urandom_range(0, 31));
    IF_PC = ($urandom_range(0, 1) == 0) ? pc : 16'($urandom_range(0, 31));
    EX_Valid = ($urandom_range(0, 3) != 0);
    EX_PC = pc;
    EX_Taken = 1'($urandom_range(0, 1));
    EX_Target = 16'(16'h0100 + 16 * $urandom_range(0, 3));
    if ($urandom_range(0, 3) != 0) begin
      EX_PredTaken = expPredTaken(pc);
      EX_PredTarget = expPredTarget(pc);
    end else begin
      EX_PredTaken = 1'($urandom_range(0, 1));
      EX_PredTarget = 16'($urandom_range(0, 65535));
    end
    Flush_All = ($urandom_range(0, 49) == 0);
    Dbg_Idx = 3'($urandom_range(0, 7));
    runCycle();
  endtask

  initial begin
    RST = 1'b0;
    idleEx();
    IF_PC = 16'h0002;
    Flush_All = 1'b0;
    Dbg_Idx = 3'd0;
    modelReset();

    // Reset then lookup
    #10;
    checkVal("rst_pred_taken", 16'(Pred_Taken), 16'h0000);
    checkVal("rst_pred_target", Pred_Target, 16'h0003);
    checkVal("rst_branch_count", Branch_Count, 16'h0000);
    checkVal("rst_mis_count", Mispredict_Count, 16'h0000);
    checkDbgAll("rst");
    RST = 1'b1;
    @(posedge CLK);
    #1;

    // Allocate on taken branch
    driveEx(1'b1, 16'h0002, 1'b1, 16'h0004, 1'b0, 16'h0003);
    IF_PC = 16'h0002;
    #1;
    checkVal("alloc_mispredict", 16'(Mispredict), 16'h0001);
    checkVal("alloc_redirect", Redirect_PC, 16'h0004);
    runCycle();
    idleEx();
    #1;
    checkVal("alloc_pred_taken", 16'(Pred_Taken), 16'h0001);
    checkVal("alloc_pred_target", Pred_Target, 16'h0004);
    checkVal("alloc_mis_count", Mispredict_Count, 16'h0001);

    // Saturation up, then two steps down
    repeat (3) begin
      driveEx(1'b1, 16'h0002, 1'b1, 16'h0004, 1'b1, 16'h0004);
      runCycle();
    end
    idleEx();
    Dbg_Idx = 3'd2;
    #1;
    checkVal("sat_ctr_max", 16'(Dbg_Value[14:13]), 16'h0003);
    driveEx(1'b1, 16'h0002, 1'b0, 16'h0000, 1'b1, 16'h0004);
    runCycle();
    idleEx();
    #1;
    checkVal("sat_ctr_down1", 16'(Dbg_Value[14:13]), 16'h0002);
    checkVal("sat_pred_down1", 16'(Pred_Taken), 16'h0001);
    driveEx(1'b1, 16'h0002, 1'b0, 16'h0000, 1'b1, 16'h0004);
    runCycle();
    idleEx();
    #1;
    checkVal("sat_ctr_down2", 16'(Dbg_Value[14:13]), 16'h0001);
    checkVal("sat_pred_down2", 16'(Pred_Taken), 16'h0000);
    checkVal("sat_target_down2", Pred_Target, 16'h0003);

    // Alias: same index, different tag
    repeat (2) begin
      driveEx(1'b1, 16'h0002, 1'b1, 16'h0004, 1'b0, 16'h0003);
      runCycle();
    end
    idleEx();
    IF_PC = 16'h000A;
    #1;
    checkVal("alias_pred_taken", 16'(Pred_Taken), 16'h0000);
    checkVal("alias_pred_target", Pred_Target, 16'h000B);
    driveEx(1'b1, 16'h000A, 1'b1, 16'h0020, 1'b0, 16'h000B);
    runCycle();
    idleEx();
    #1;
    checkVal("alias_new_taken", 16'(Pred_Taken), 16'h0001);
    checkVal("alias_new_target", Pred_Target, 16'h0020);
    IF_PC = 16'h0002;
    #1;
    checkVal("alias_old_taken", 16'(Pred_Taken), 16'h0000);

    // Correct prediction, then not-taken redirect wrapping at the top of memory
    driveEx(1'b1, 16'h000A, 1'b1, 16'h0020, 1'b1, 16'h0020);
    #1;
    checkVal("correct_mispredict", 16'(Mispredict), 16'h0000);
    runCycle();
    driveEx(1'b1, 16'hFFFF, 1'b0, 16'h1234, 1'b1, 16'h1234);
    #1;
    checkVal("wrap_mispredict", 16'(Mispredict), 16'h0001);
    checkVal("wrap_redirect", Redirect_PC, 16'h0000);
    runCycle();

    // Flush beats a coincident taken update
    Flush_All = 1'b1;
    driveEx(1'b1, 16'h0005, 1'b1, 16'h0030, 1'b0, 16'h0006);
    runCycle();
    Flush_All = 1'b0;
    idleEx();
    checkDbgAll("flush");
    Dbg_Idx = 3'd5;
    IF_PC = 16'h000A;
    #1;
    checkVal("flush_drop_update", Dbg_Value, 16'h2000);
    checkVal("flush_pred_taken", 16'(Pred_Taken), 16'h0000);

    // Randomized traffic
    @(posedge CLK);
    #1;
    repeat (400) randomCycle();

    // Asynchronous reset mid-cycle
    Flush_All = 1'b0;
    idleEx();
    @(posedge CLK);
    #3;
    RST = 1'b0;
    modelReset();
    #1;
    checkVal("async_branch_count", Branch_Count, 16'h0000);
    checkVal("async_mis_count", Mispredict_Count, 16'h0000);
    checkDbgAll("async");
    RST = 1'b1;
    @(posedge CLK);
    #1;
    repeat (100) randomCycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
